// File: rtl/cpu_controller_if.sv
// ============================================================================
// Module   : cpu_controller_if
// Brief    : Instruction-memory, ALU-control and flag bundle of the CPU
//            sequencer. The master is the controller, the slave is the
//            memory/ALU side.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cpu_controller_if;
    logic [7:0] instr_CTRL_in;
    logic       imem_ack_CTRL;
    logic       CF_CTRL_in;
    logic       ZF_CTRL_in;
    logic [7:0] pc_CTRL_out;
    logic       imem_req_CTRL;
    logic [2:0] f_CTRL_out;
    logic       write_cz_CTRL;
    logic       alu_en_CTRL;
    logic       halt_CTRL;

    modport master (
        input  instr_CTRL_in, imem_ack_CTRL, CF_CTRL_in, ZF_CTRL_in,
        output pc_CTRL_out, imem_req_CTRL, f_CTRL_out, write_cz_CTRL,
               alu_en_CTRL, halt_CTRL
    );

    modport slave (
        output instr_CTRL_in, imem_ack_CTRL, CF_CTRL_in, ZF_CTRL_in,
        input  pc_CTRL_out, imem_req_CTRL, f_CTRL_out, write_cz_CTRL,
               alu_en_CTRL, halt_CTRL
    );
endinterface

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module   : cpu_controller
// Brief    : Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
//            Drives the ALU controls and resolves conditional jumps.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_controller (
    input  wire logic        clk_CTRL,
    input  wire logic        rst_CTRL,
    cpu_controller_if.master ctrl_bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_FETCH2 = 3'd4,
        S_JUMP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     r_state;
    logic       r_idle_done;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_tgt;
    logic       r_req;
    logic [2:0] r_f;
    logic       r_wcz;
    logic       r_alu_en;
    logic       r_halt;

    logic       w_hs;
    logic       w_taken;

    assign w_hs = r_req & ctrl_bus.imem_ack_CTRL;

    // Jump condition from IR[5:4], using the flags present during JUMP.
    always_comb begin
        w_taken = 1'b0;
        case (r_ir[5:4])
            2'b00:   w_taken = 1'b1;
            2'b01:   w_taken = ctrl_bus.ZF_CTRL_in;
            2'b10:   w_taken = ctrl_bus.CF_CTRL_in;
            default: w_taken = ~ctrl_bus.ZF_CTRL_in;
        endcase
    end

    always_ff @(posedge clk_CTRL) begin
        if (rst_CTRL) begin
            r_state     <= S_IDLE;
            r_idle_done <= 1'b0;
            r_pc        <= 8'h00;
            r_ir        <= 8'h00;
            r_tgt       <= 8'h00;
            r_req       <= 1'b0;
            r_f         <= 3'b000;
            r_wcz       <= 1'b0;
            r_alu_en    <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            case (r_state)
                // One full idle cycle after reset release before fetching.
                S_IDLE: begin
                    if (r_idle_done) begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end else begin
                        r_idle_done <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_hs) begin
                        r_ir    <= ctrl_bus.instr_CTRL_in;
                        r_pc    <= r_pc + 8'd1;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (r_ir[7:6])
                        2'b00: begin
                            r_alu_en <= 1'b1;
                            r_f      <= r_ir[2:0];
                            r_wcz    <= r_ir[3];
                            r_state  <= S_EXEC;
                        end
                        2'b01: begin
                            r_req   <= 1'b1;
                            r_state <= S_FETCH2;
                        end
                        default: begin
                            r_halt  <= 1'b1;
                            r_state <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    r_alu_en <= 1'b0;
                    r_wcz    <= 1'b0;
                    r_req    <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_FETCH2: begin
                    if (w_hs) begin
                        r_tgt   <= ctrl_bus.instr_CTRL_in;
                        r_pc    <= r_pc + 8'd1;
                        r_req   <= 1'b0;
                        r_state <= S_JUMP;
                    end
                end
                S_JUMP: begin
                    if (w_taken) begin
                        r_pc <= r_tgt;
                    end
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_req    <= 1'b0;
                    r_alu_en <= 1'b0;
                    r_wcz    <= 1'b0;
                    r_halt   <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_bus.pc_CTRL_out   = r_pc;
    assign ctrl_bus.imem_req_CTRL = r_req;
    assign ctrl_bus.f_CTRL_out    = r_f;
    assign ctrl_bus.write_cz_CTRL = r_wcz;
    assign ctrl_bus.alu_en_CTRL   = r_alu_en;
    assign ctrl_bus.halt_CTRL     = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module   : tb_cpu_controller
// Brief    : Scoreboard bench: an ISA-level model predicts fetches, ALU
//            executions and halts; a monitor/memory process checks the DUT.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk_CTRL (clk),
        .rst_CTRL (rst),
        .ctrl_bus (bus)
    );

    typedef struct {
        int kind;   // 0 fetch, 1 exec, 2 halt
        int val;
        int gap;
        bit jump2;
        int cf;
        int zf;
    } ev_t;

    ev_t        sbq[$];
    logic [7:0] mem [256];
    int         n_cmp = 0;
    int         n_err = 0;
    int         fixed_cf = -1;
    int         fixed_zf = -1;
    int         force_wait = -1;
    bit         trunc = 1'b0;
    bit         armed = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int k, input int v, input int g, input bit j,
                           input int cf, input int zf);
        ev_t e;
        e.kind = k; e.val = v; e.gap = g; e.jump2 = j; e.cf = cf; e.zf = zf;
        sbq.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.val = 0; e.gap = -1; e.jump2 = 1'b0; e.cf = 0; e.zf = 0;
        if (sbq.size() == 0) begin
            if (!trunc) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
            end
        end else begin
            e = sbq.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Instruction-level reference: walks the program and lists observable events.
    task automatic build_expected();
        int pc, gap, n, b, t, cc, cf, zf;
        bit taken;
        pc = 0; gap = -1; n = 0; trunc = 1'b0;
        sbq.delete();
        forever begin
            if (n >= 40) begin
                trunc = 1'b1;
                break;
            end
            b = int'(mem[pc]);
            push_ev(0, pc, gap, 1'b0, 0, 0);
            pc = (pc + 1) % 256;
            if (b / 64 == 0) begin
                push_ev(1, b % 16, 0, 1'b0, 0, 0);
                gap = 3;
            end else if (b / 64 == 1) begin
                cf = (fixed_cf >= 0) ? fixed_cf : int'($urandom_range(1));
                zf = (fixed_zf >= 0) ? fixed_zf : int'($urandom_range(1));
                push_ev(0, pc, 2, 1'b1, cf, zf);
                t  = int'(mem[pc]);
                pc = (pc + 1) % 256;
                cc = (b / 16) % 4;
                taken = (cc == 0) || (cc == 1 && zf == 1) ||
                        (cc == 2 && cf == 1) || (cc == 3 && zf == 0);
                if (taken) pc = t;
                gap = 2;
            end else begin
                push_ev(2, 0, 0, 1'b0, 0, 0);
                break;
            end
            n++;
        end
    endtask

    function automatic int pick_wait();
        if (force_wait >= 0) return force_wait;
        return ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
    endfunction

    // Memory responder, flag driver and monitor; runs 2ns after each falling edge.
    initial begin : monitor
        int cyc, last_hs, wcnt, wtarget, jcf, jzf;
        bit in_jump, prev_halt, waiting, ok;
        logic [2:0] last_f;
        logic [7:0] held_pc;
        ev_t e;
        cyc = 0; last_hs = 0; wcnt = 0; wtarget = 0; jcf = 0; jzf = 0;
        in_jump = 1'b0; prev_halt = 1'b0; waiting = 1'b0; ok = 1'b0;
        last_f = 3'b000; held_pc = 8'h00;
        bus.imem_ack_CTRL = 1'b0;
        bus.instr_CTRL_in = 8'h00;
        bus.CF_CTRL_in    = 1'b0;
        bus.ZF_CTRL_in    = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst || !armed) begin
                bus.imem_ack_CTRL = 1'b1;
                bus.instr_CTRL_in = 8'($urandom);
                bus.CF_CTRL_in    = 1'($urandom);
                bus.ZF_CTRL_in    = 1'($urandom);
                wcnt = 0; wtarget = pick_wait(); in_jump = 1'b0;
                prev_halt = 1'b0; waiting = 1'b0; last_f = 3'b000; last_hs = cyc;
            end else begin
                if (!bus.alu_en_CTRL) begin
                    chk("wcz_outside_exec", int'(bus.write_cz_CTRL), 0);
                    chk("f_hold", int'(bus.f_CTRL_out), int'(last_f));
                end else begin
                    pop_ev(1, e, ok);
                    if (ok) chk("exec_wf", int'({bus.write_cz_CTRL, bus.f_CTRL_out}), e.val);
                    last_f = bus.f_CTRL_out;
                end
                if (bus.halt_CTRL) chk("req_while_halted", int'(bus.imem_req_CTRL), 0);
                if (bus.halt_CTRL && !prev_halt) pop_ev(2, e, ok);
                prev_halt = bus.halt_CTRL;

                if (in_jump) begin
                    bus.CF_CTRL_in = 1'(jcf);
                    bus.ZF_CTRL_in = 1'(jzf);
                end else begin
                    bus.CF_CTRL_in = 1'($urandom);
                    bus.ZF_CTRL_in = 1'($urandom);
                end
                in_jump = 1'b0;

                if (waiting) chk("req_held_in_wait", int'(bus.imem_req_CTRL), 1);
                if (bus.imem_req_CTRL) begin
                    if (waiting) chk("pc_stable_in_wait", int'(bus.pc_CTRL_out), int'(held_pc));
                    if (wcnt < wtarget) begin
                        bus.imem_ack_CTRL = 1'b0;
                        bus.instr_CTRL_in = 8'($urandom);
                        wcnt++;
                        waiting = 1'b1;
                        held_pc = bus.pc_CTRL_out;
                    end else begin
                        bus.imem_ack_CTRL = 1'b1;
                        bus.instr_CTRL_in = mem[bus.pc_CTRL_out];
                        pop_ev(0, e, ok);
                        if (ok) begin
                            chk("fetch_pc", int'(bus.pc_CTRL_out), e.val);
                            if (e.gap >= 0) chk("fetch_gap", cyc - last_hs - wcnt, e.gap);
                            if (e.jump2) begin
                                in_jump = 1'b1;
                                jcf = e.cf;
                                jzf = e.zf;
                            end
                        end
                        last_hs = cyc; wcnt = 0; wtarget = pick_wait(); waiting = 1'b0;
                    end
                end else begin
                    waiting = 1'b0;
                    bus.imem_ack_CTRL = 1'($urandom);
                    bus.instr_CTRL_in = 8'($urandom);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        armed = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({bus.pc_CTRL_out, bus.imem_req_CTRL, bus.f_CTRL_out,
                                   bus.write_cz_CTRL, bus.alu_en_CTRL, bus.halt_CTRL}), 0);
        @(negedge clk);
    endtask

    task automatic go();
        build_expected();
        rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("req_after_1st_edge", int'(bus.imem_req_CTRL), 0);
        @(negedge clk);
        chk("req_after_2nd_edge", int'(bus.imem_req_CTRL), 1);
        chk("first_pc", int'(bus.pc_CTRL_out), 0);
        for (int i = 0; i < 4000; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL program_timeout: got %0d pending events expected 0", sbq.size());
            sbq.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(99));
            if (r < 50)      mem[i] = {2'b00, 6'($urandom)};
            else if (r < 85) mem[i] = {2'b01, 6'($urandom)};
            else if (r < 90) mem[i] = {1'b1, 7'($urandom)};
            else             mem[i] = 8'($urandom);
        end
    endtask

    initial begin : stimulus
        @(negedge clk);

        do_reset(); fill(8'hC0); mem[0] = 8'h0C; force_wait = 0; go();
        do_reset(); fill(8'hC0); mem[0] = 8'h05; force_wait = 3; go();
        force_wait = -1;

        do_reset(); fill(8'hC0); mem[0] = 8'h50; mem[1] = 8'h20; fixed_zf = 1; go();
        do_reset(); fill(8'hC0); mem[0] = 8'h50; mem[1] = 8'h20; fixed_zf = 0; go();
        fixed_zf = -1;
        do_reset(); fill(8'hC0); mem[0] = 8'h60; mem[1] = 8'h80; fixed_cf = 1; go();
        fixed_cf = -1;

        // Jump at 0xFF whose target byte wraps around to address 0x00.
        do_reset(); fill(8'hC0);
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h40; mem[8'h02] = 8'hFF; mem[8'hFF] = 8'h40;
        go();

        do_reset(); fill(8'hC0); go();

        for (int p = 0; p < 14; p++) begin
            do_reset(); fill_random(); go();
        end

        // Reset landing on a fetch edge while ack is high.
        do_reset(); fill(8'h01); force_wait = 0; go();
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req_CTRL) break;
            @(negedge clk);
        end
        chk("req_before_midop_reset", int'(bus.imem_req_CTRL), 1);
        do_reset();
        force_wait = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It sits directly upstream of the ALU. It fetches instruction bytes from instruction memory over a req/ack handshake, maintains the 8-bit program counter, and decodes each instruction. It drives the ALU function select, the flag write strobe and a datapath enable, and resolves conditional jumps from the ALU carry/zero flags.

## Interface
- No parameters; widths fixed at 8-bit data/address, 3-bit ALU function.
- clk_CTRL  input  1  system clock, rising-edge.
- rst_CTRL  input  1  reset, synchronous, active-high.
- instr_CTRL_in  input  8  instruction byte from instruction memory.
- imem_ack_CTRL  input  1  memory has valid data on instr_CTRL_in this cycle.
- CF_CTRL_in  input  1  carry flag from ALU (CF_ALU_out).
- ZF_CTRL_in  input  1  zero flag from ALU (ZF_ALU_out).
- pc_CTRL_out  output  8  instruction memory address.
- imem_req_CTRL  output  1  fetch request.
- f_CTRL_out  output  3  ALU function select (to ALU f).
- write_cz_CTRL  output  1  ALU flag write strobe (to ALU write_cz).
- alu_en_CTRL  output  1  datapath clock-enable; the ALU registers update only when it is 1.
- halt_CTRL  output  1  CPU halted.

## Operation
- Instruction encoding (byte 0):
  - 00 w fff: ALU op. f = fff, write_cz = w. One byte.
  - 01 cc xxxx: jump. cc=00 JMP always, 01 JZ, 10 JC, 11 JNZ. Byte 1 is the absolute 8-bit target.
  - 11 xxxxxx and 10 xxxxxx: HALT.
- States: IDLE, FETCH, DECODE, EXEC, FETCH2, JUMP, HALT.
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: imem_req_CTRL=1, pc_CTRL_out=PC. On an edge with req&ack, latch instr_CTRL_in into IR, PC<=PC+1, go to DECODE. Otherwise stay.
  - DECODE: opcode 00 -> EXEC; 01 -> FETCH2; 1x -> HALT.
  - EXEC: alu_en_CTRL=1, f_CTRL_out=IR[2:0], write_cz_CTRL=IR[3] for exactly one cycle, then FETCH.
  - FETCH2: same handshake as FETCH. The byte is latched into TGT, PC<=PC+1, then JUMP.
  - JUMP: evaluate the condition on CF_CTRL_in/ZF_CTRL_in sampled this cycle. If taken, PC<=TGT; otherwise PC keeps its incremented value. Then FETCH.
  - HALT: halt_CTRL=1. Stays until rst_CTRL.
- f_CTRL_out holds its last value outside EXEC. write_cz_CTRL and alu_en_CTRL are 0 outside EXEC.
- PC arithmetic is modulo 256: 0xFF+1 -> 0x00, including mid-instruction between byte 0 and byte 1.
- imem_ack_CTRL is ignored when imem_req_CTRL=0. imem_req_CTRL stays high with stable pc_CTRL_out until ack.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from input to output.
- Reset (edge with rst_CTRL=1): state IDLE, PC=0x00, IR=0x00, TGT=0x00.
  - Outputs: pc_CTRL_out=0x00, imem_req_CTRL=0, f_CTRL_out=000, write_cz_CTRL=0, alu_en_CTRL=0, halt_CTRL=0.
- Reset asserted in any state, including mid-handshake or in HALT, wins on that edge. An in-flight ack is discarded.
- First imem_req_CTRL: 2nd edge after rst_CTRL falls (IDLE, then FETCH).
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Jump: 4 cycles (FETCH, DECODE, FETCH2, JUMP).
  - Each wait cycle (req=1, ack=0) adds one cycle.
- Flags are sampled in JUMP. An ALU EXEC immediately preceding the jump has updated the ALU flags at its closing edge, so they are visible in JUMP.

## Test plan
- Reset: hold rst_CTRL=1 for 2 cycles, then release -> all outputs at reset values; imem_req_CTRL rises on the 2nd edge after release with pc_CTRL_out=0x00.
- ALU op with zero wait: memory returns 0x0C -> exactly one cycle with alu_en_CTRL=1, f_CTRL_out=100, write_cz_CTRL=1; next fetch at PC=0x01, 3 cycles after the first.
- Wait states: ack delayed 3 cycles on a fetch of 0x05 -> req and pc held stable for 4 cycles; EXEC has f=101, write_cz=0.
- Conditional jump: program 0x50,0x20 with ZF_CTRL_in=1 -> next fetch at 0x20; with ZF=0 -> next fetch at 0x02. Also 0x60,0x80 with CF=1 -> 0x80.
- Wrap: PC=0xFF holding 0x40, byte at 0x00 = 0x10 -> target 0x10 fetched; no X on pc_CTRL_out.
- HALT and mid-operation reset: fetch 0xC0 -> halt_CTRL=1 and no further req. Asserting rst_CTRL during a FETCH with ack=1 -> next cycle in IDLE with PC=0x00 and no IR update.
